// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the byte-serial memory bridge: state encoding and lane geometry.
package mem_bridge_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_TAIL = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mem_lane_sel.sv
// Combinational lowest-set-lane finder; none=1 when the mask is empty.
module mem_lane_sel
    import mem_bridge_pkg::*;
(
    input  logic [LANES-1:0] mask,
    output logic [1:0]       idx,
    output logic             none
);

    always_comb begin
        idx  = 2'd0;
        none = 1'b1;
        // Scan downward so the lowest set lane is the last one written.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx  = 2'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_byte_bridge.sv
// Word request to byte-wide SRAM bridge, one byte per cycle with a done pulse.
// Build option: MEM_BYTE_BRIDGE_RDMASK_EN makes reads fetch only lanes set in req_wrbits.
//
// state   | meaning
// IDLE    | waiting; requests sampled here only
// RD      | issuing one read lane per cycle
// RD_TAIL | capturing the last returned byte
// WR      | strobing one set lane per cycle
// DONE    | resp_done pulse
module mem_byte_bridge
    import mem_bridge_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_read,
    input  logic          req_write,
    input  logic [31:0]   req_addr,
    input  logic [3:0]    req_wrbits,
    input  logic [31:0]   req_wdata,
    output logic          busy,
    output logic          resp_done,
    output logic [31:0]   resp_rdata,
    output logic [AW-1:0] sram_addr,
    output logic          sram_oe,
    output logic          sram_we,
    output logic [7:0]    sram_wdata,
    input  logic [7:0]    sram_rdata
);

    state_t             state_q, state_d;
    logic [AW-3:0]      base_q, base_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [LANES-1:0]   rem_q, rem_d;
    logic [1:0]         lane_q, lane_d;
    logic               pend_q, pend_d;
    logic [1:0]         pend_lane_q, pend_lane_d;

    logic [LANES-1:0]   rem_after;
    logic [LANES-1:0]   rd_mask;
    logic [LANES-1:0]   sel_mask;
    logic [1:0]         sel_idx;
    logic               sel_none;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW], req_addr[1:0]};

`ifdef MEM_BYTE_BRIDGE_RDMASK_EN
    assign rd_mask = req_wrbits;
`else
    assign rd_mask = 4'hF;
`endif

    assign rem_after = rem_q & ~(4'b0001 << lane_q);

    mem_lane_sel u_lane_sel (
        .mask (sel_mask),
        .idx  (sel_idx),
        .none (sel_none)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rem_d       = rem_q;
        lane_d      = lane_q;
        pend_d      = (state_q == ST_RD);
        pend_lane_d = lane_q;
        sel_mask    = rem_after;

        // Byte issued last cycle lands now.
        if (pend_q) begin
            rdata_d[{pend_lane_q, 3'b000} +: BYTE_W] = sram_rdata;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req_write) begin
                    sel_mask = req_wrbits;
                    base_d   = req_addr[AW-1:2];
                    wdata_d  = req_wdata;
                    rem_d    = req_wrbits;
                    lane_d   = sel_none ? 2'd0 : sel_idx;
                    state_d  = sel_none ? ST_DONE : ST_WR;
                end else if (req_read) begin
                    sel_mask = rd_mask;
                    base_d   = req_addr[AW-1:2];
                    rdata_d  = 32'h0;
                    rem_d    = rd_mask;
                    lane_d   = sel_none ? 2'd0 : sel_idx;
                    state_d  = sel_none ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                rem_d = rem_after;
                if (sel_none) state_d = ST_RD_TAIL;
                else          lane_d  = sel_idx;
            end
            ST_WR: begin
                rem_d = rem_after;
                if (sel_none) state_d = ST_DONE;
                else          lane_d  = sel_idx;
            end
            ST_RD_TAIL: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rem_q       <= '0;
            lane_q      <= '0;
            pend_q      <= 1'b0;
            pend_lane_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rem_q       <= rem_d;
            lane_q      <= lane_d;
            pend_q      <= pend_d;
            pend_lane_q <= pend_lane_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign resp_done  = (state_q == ST_DONE);
    assign resp_rdata = rdata_q;
    assign sram_oe    = (state_q == ST_RD);
    assign sram_we    = (state_q == ST_WR);
    assign sram_addr  = {base_q, lane_q};
    assign sram_wdata = wdata_q[{lane_q, 3'b000} +: BYTE_W];

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Directed bench for mem_byte_bridge with a byte SRAM model and an SRAM-event scoreboard.
module tb_mem_byte_bridge;

    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_read, req_write;
    logic [31:0]   req_addr;
    logic [3:0]    req_wrbits;
    logic [31:0]   req_wdata;
    logic          busy, resp_done;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_oe, sram_we;
    logic [7:0]    sram_wdata;
    logic [7:0]    sram_rdata;

    always #5 clock = ~clock;

    mem_byte_bridge #(.AW(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wrbits (req_wrbits),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_done  (resp_done),
        .resp_rdata (resp_rdata),
        .sram_addr  (sram_addr),
        .sram_oe    (sram_oe),
        .sram_we    (sram_we),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    bit [7:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_oe) sram_rdata <= mem[sram_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        int          c;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    always @(negedge clock) begin
        if (sram_oe) obs_q.push_back(ev_t'{we: 1'b0, addr: sram_addr, data: 8'h00, c: cyc});
        if (sram_we) obs_q.push_back(ev_t'{we: 1'b1, addr: sram_addr, data: sram_wdata, c: cyc});
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expect_ev(input logic we, input logic [15:0] addr, input logic [7:0] d, input int c);
        exp_q.push_back(ev_t'{we: we, addr: addr, data: d, c: c});
    endtask

    task automatic check_events(input string tag);
        ev_t o, e;
        chk({tag, " event count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, " event"}, 64'(o), 64'(e));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Called at a negedge while the DUT is idle; that cycle is A.
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] wd, input int exp_lat,
                           input logic chk_rd, input logic [31:0] exp_rd,
                           input logic perturb);
        int  a, lat, busy_cnt;
        bit  got;
        a = cyc;
        got = 0; lat = -1; busy_cnt = 0;
        req_read = rd; req_write = wr; req_addr = addr;
        req_wrbits = mask; req_wdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (perturb && i == 0) begin
                req_addr  = 32'h0000_0500;
                req_wdata = 32'hFFFF_FFFF;
                req_read  = 1'b1;
            end
            if (busy) busy_cnt++;
            if (resp_done) begin
                got = 1;
                lat = cyc - a;
                if (chk_rd) chk({tag, " rdata"}, 64'(resp_rdata), 64'(exp_rd));
                req_read  = 1'b0;
                req_write = 1'b0;
            end
        end
        chk({tag, " done latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
        @(negedge clock);
        chk({tag, " idle after"}, 64'(busy), 64'(0));
        check_events(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"},       64'(busy),       64'(0));
        chk({tag, " resp_done"},  64'(resp_done),  64'(0));
        chk({tag, " resp_rdata"}, 64'(resp_rdata), 64'(0));
        chk({tag, " sram_addr"},  64'(sram_addr),  64'(0));
        chk({tag, " sram_oe"},    64'(sram_oe),    64'(0));
        chk({tag, " sram_we"},    64'(sram_we),    64'(0));
        chk({tag, " sram_wdata"}, 64'(sram_wdata), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int a, dones;
        reset = 1'b1; req_read = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wrbits = '0; req_wdata = '0;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clock);

        // Load 0x11..0x44 at 0x100..0x103.
        a = cyc;
        for (int k = 0; k < 4; k++) expect_ev(1'b1, 16'h0100 + 16'(k), 8'(8'h11 * (k + 1)), a + 1 + k);
        run_req("wr_full", 1'b0, 1'b1, 32'h100, 4'b1111, 32'h4433_2211, 5, 1'b0, 32'h0, 1'b0);

        a = cyc;
        for (int k = 0; k < 4; k++) expect_ev(1'b0, 16'h0100 + 16'(k), 8'h00, a + 1 + k);
        run_req("rd_0x102", 1'b1, 1'b0, 32'h102, 4'b0000, 32'h0, 6, 1'b1, 32'h4433_2211, 1'b0);

        a = cyc;
        expect_ev(1'b1, 16'h0200, 8'hDD, a + 1);
        expect_ev(1'b1, 16'h0202, 8'hBB, a + 2);
        run_req("wr_0101", 1'b0, 1'b1, 32'h200, 4'b0101, 32'hAABB_CCDD, 3, 1'b0, 32'h0, 1'b0);

        a = cyc;
        for (int k = 0; k < 4; k++) expect_ev(1'b0, 16'h0200 + 16'(k), 8'h00, a + 1 + k);
        run_req("rd_0x200", 1'b1, 1'b0, 32'h200, 4'b1111, 32'h0, 6, 1'b1, 32'h00BB_00DD, 1'b0);

        run_req("wr_0000", 1'b0, 1'b1, 32'h300, 4'b0000, 32'h1234_5678, 1, 1'b0, 32'h0, 1'b0);

        // Read and write together, request changed while busy.
        a = cyc;
        for (int k = 0; k < 4; k++) expect_ev(1'b1, 16'h0400 + 16'(k), 8'(4 - k), a + 1 + k);
        run_req("rd_wr_both", 1'b1, 1'b1, 32'h400, 4'b1111, 32'h0102_0304, 5, 1'b0, 32'h0, 1'b1);

`ifdef MEM_BYTE_BRIDGE_RDMASK_EN
        a = cyc;
        expect_ev(1'b0, 16'h0103, 8'h00, a + 1);
        run_req("rd_mask1000", 1'b1, 1'b0, 32'h101, 4'b1000, 32'h0, 3, 1'b1, 32'h4400_0000, 1'b0);
`else
        a = cyc;
        for (int k = 0; k < 4; k++) expect_ev(1'b0, 16'h0100 + 16'(k), 8'h00, a + 1 + k);
        run_req("rd_mask1000", 1'b1, 1'b0, 32'h101, 4'b1000, 32'h0, 6, 1'b1, 32'h4433_2211, 1'b0);
`endif

        // Reset during A+2 of a four-lane write.
        a = cyc;
        expect_ev(1'b1, 16'h0600, 8'hA0, a + 1);
        expect_ev(1'b1, 16'h0601, 8'hA1, a + 2);
        req_write = 1'b1; req_addr = 32'h600; req_wrbits = 4'b1111; req_wdata = 32'hA3A2_A1A0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        req_write = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (resp_done) dones++;
        end
        chk("mid_reset done pulses", 64'(dones), 64'(0));
        chk_reset_vals("mid_reset");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("post_reset idle", 64'(busy), 64'(0));
        check_events("mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
